// File: rtl/ahb_master_engine.sv
// ahb_master_engine: AHB-Lite master turning a command/write-data stream into SINGLE/INCR4 transfers with wait, BUSY and ERROR handling.
module ahb_master_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic              cmd_incr4,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);
  typedef enum logic [2:0] {IDLE, ADDR, BUSYW, DRAIN, ERR2} state_t;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  state_t state;
  logic [DATA_W-1:0] stage;
  logic stage_full, dp_valid, dp_last;
  logic [1:0] beat;
  logic [2:0] wcnt;
  logic accept, addr_done, incr, last_beat, dp_err, wdata_hs;
  assign HPROT = 4'b0011;
  assign HMASTLOCK = 1'b0;
  // wdata_ready may refill staging in the same cycle it drains, keeping write bursts gap-free
  always_comb begin
    accept = cmd_ready && cmd_valid && (!cmd_write || wdata_valid);
    addr_done = (state == ADDR) && HREADY;
    incr = HBURST == 3'b011;
    last_beat = beat == (incr ? 2'd3 : 2'd0);
    dp_err = dp_valid && HRESP && !HREADY;
    wdata_ready = (state == IDLE) ? cmd_ready && cmd_write :
      HWRITE && (state == ADDR || state == BUSYW) && wcnt != (incr ? 3'd4 : 3'd1) && (!stage_full || addr_done);
    wdata_hs = wdata_valid && wdata_ready;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      HADDR <= '0;
      HTRANS <= T_IDLE;
      HWRITE <= 1'b0;
      HSIZE <= 3'd0;
      HBURST <= 3'd0;
      HWDATA <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
      rsp_err <= 1'b0;
      stage <= '0;
      stage_full <= 1'b0;
      dp_valid <= 1'b0;
      dp_last <= 1'b0;
      beat <= 2'd0;
      wcnt <= 3'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last <= 1'b0;
      rsp_err <= 1'b0;
      if (wdata_hs && state != IDLE) begin
        stage <= wdata;
        stage_full <= 1'b1;
        wcnt <= wcnt + 3'd1;
      end else if (addr_done) stage_full <= 1'b0;
      if (HREADY && dp_valid) begin
        rsp_valid <= 1'b1;
        rsp_last <= dp_last;
        rsp_data <= HWRITE ? '0 : HRDATA;
        dp_valid <= 1'b0;
      end
      if (addr_done) begin
        dp_valid <= 1'b1;
        dp_last <= last_beat;
        if (HWRITE) HWDATA <= stage;
      end
      // first error cycle: cancel whatever address is pending
      if (dp_err) begin
        HTRANS <= T_IDLE;
        dp_valid <= 1'b0;
        state <= ERR2;
      end else begin
        case (state)
          IDLE: begin
            cmd_ready <= !accept;
            if (accept) begin
              state <= ADDR;
              HTRANS <= T_NSEQ;
              HADDR <= cmd_addr;
              HWRITE <= cmd_write;
              HSIZE <= cmd_size;
              HBURST <= cmd_incr4 ? 3'b011 : 3'b000;
              beat <= 2'd0;
              wcnt <= 3'd1;
              stage <= wdata;
              stage_full <= cmd_write;
            end
          end
          ADDR: if (HREADY) begin
            if (last_beat) begin
              HTRANS <= T_IDLE;
              state <= DRAIN;
            end else begin
              beat <= beat + 2'd1;
              HADDR <= HADDR + (ADDR_W'(1) << HSIZE);
              HTRANS <= (HWRITE && !wdata_hs) ? T_BUSY : T_SEQ;
              state <= (HWRITE && !wdata_hs) ? BUSYW : ADDR;
            end
          end
          BUSYW: if (HREADY && (stage_full || wdata_hs)) begin
            HTRANS <= T_SEQ;
            state <= ADDR;
          end
          DRAIN: if (HREADY) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
          end
          ERR2: if (HREADY) begin
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_last <= 1'b1;
            rsp_data <= HWRITE ? '0 : HRDATA;
            stage_full <= 1'b0;
            state <= IDLE;
            cmd_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/ahb_master_engine.md
# ahb_master_engine

AHB-Lite master that converts a simple command/write-data/response stream into protocol-legal transfers on the AHB bus. It is the stage directly upstream of the bus checker and the slave models: it drives the master-side AHB signals, handles pipelined address and data phases, wait states, BUSY insertion and two-cycle ERROR responses. Supported transfers are SINGLE and INCR4 bursts, byte to word size.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; HSIZE is limited to log2(DATA_W/8)

- HCLK  in  1  bus clock; all state is on the rising edge
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  start address; must be aligned to cmd_size
- cmd_size  in  3  HSIZE value
- cmd_incr4  in  1  1 = INCR4, 0 = SINGLE
- wdata_valid / wdata_ready  in/out  1  write-data handshake, one transfer per beat
- wdata  in  DATA_W  write beat data
- rsp_valid  out  1  one pulse per completed beat; no backpressure
- rsp_data  out  DATA_W  HRDATA for reads, 0 for writes
- rsp_last, rsp_err  out  1  final beat of the command / error on this beat
- HADDR  out  ADDR_W; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HPROT  out  4 (constant 4'b0011); HMASTLOCK  out  1 (constant 0); HWDATA  out  DATA_W
- HRDATA  in  DATA_W; HREADY  in  1; HRESP  in  1

## Operation
- States: IDLE, ADDR (beat address phase driven), BUSYW (burst stalled on write data), DRAIN (last data phase only), ERR2 (second error cycle).
- IDLE: cmd_ready=1. For writes, acceptance requires cmd_valid & wdata_valid; beat 0 data is consumed with the command, so wdata_ready=cmd_ready & cmd_write in IDLE.
- On accept, the next cycle drives HTRANS=NONSEQ, HBURST=INCR4 (3'b011) or SINGLE (3'b000), HADDR=cmd_addr.
- The address phase holds until HREADY=1. Beat n+1 address is driven in the same cycle as beat n data phase (pipelined). Address increment is HADDR + (1<<HSIZE), with ADDR_W wrap. Callers never issue an INCR4 that crosses a 1 KB boundary; the engine does not check.
- Write data: a one-entry staging register feeds HWDATA. Data for beat k is registered into HWDATA on the cycle its address phase completes. For beats 1..3, wdata_ready=1 while staging is empty. If staging is empty when SEQ is due, the engine drives HTRANS=BUSY with the next address. It goes to SEQ once data is staged.
- Reads: HTRANS is never BUSY.
- rsp: registered. rsp_valid pulses the cycle after a data phase completes with HREADY=1. rsp_last marks beat 0 (SINGLE) or beat 3 (INCR4).
- Error, first cycle (HRESP=1, HREADY=0): the engine drives HTRANS=IDLE in the next cycle (ERR2), cancelling the pending address.
- Error, second cycle (HRESP=1, HREADY=1): rsp_valid=1 with rsp_err=1 and rsp_last=1. Remaining beats are dropped and unused staged write data is discarded. The engine returns to IDLE.
- No new command is accepted until the final data phase completes; cmd_ready=0 outside IDLE.

## Timing
- Reset values: HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, cmd_ready=0 while HRESETn=0 (1 from the first edge after release), wdata_ready=0, rsp_valid=0, rsp_err=0, rsp_last=0.
- Reset asserted mid-burst: all outputs take reset values immediately. No rsp is issued for in-flight beats.
- Zero wait states, accept at edge T: NONSEQ at T+1, beat k address at T+1+k, beat k data at T+2+k, rsp for beat k at T+3+k. INCR4 issues its last rsp at T+6. The next command is accepted at T+6 at the earliest.
- Each HREADY=0 cycle delays all later events by one cycle. HADDR, HTRANS and HWDATA are stable while HREADY=0.
- BUSY never precedes NONSEQ and never follows the last beat.

## Test plan
- Single read 0x100, size 2, HREADY=1, HRDATA=0xCAFEF00D -> NONSEQ at T+1, rsp_valid at T+3 with rsp_data=0xCAFEF00D and rsp_last=1.
- INCR4 write 0x200, data 1..4, HREADY low 2 cycles on beat 1 -> HADDR 0x200/204/208/20C, HWDATA 1..4 held during the waits, four rsp pulses, last one with rsp_last=1.
- INCR4 write with wdata_valid low 3 cycles before beat 2 -> three BUSY cycles with HADDR=0x208, then SEQ. Protocol stays legal.
- INCR4 read with two-cycle ERROR on beat 1 -> HTRANS=IDLE in the cycle after the first error cycle. Exactly two rsp pulses, the second with rsp_err=1 and rsp_last=1. Back to IDLE.
- HRESETn low during beat 2 of INCR4 read -> outputs at reset values in the same cycle, no rsp. A fresh single read after release completes normally.
- Back-to-back singles 0x0 then 0x4 held valid -> second NONSEQ starts exactly after the first rsp cycle. No overlap between the two commands.
